// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy video path.
// Contents:
//   GB_W, GB_H, FB_DEPTH, FB_ADDR_W : frame store geometry
//   RGB_W, rgb565_t, shade_t        : pixel types
//   PAL_DEF_0..3, pal_default()     : power-on palette (light to dark green)
package gb_video_pkg;

    localparam int GB_W      = 160;
    localparam int GB_H      = 144;
    localparam int FB_DEPTH  = GB_W * GB_H;
    localparam int FB_ADDR_W = 15;
    localparam int RGB_W     = 16;

    typedef logic [RGB_W-1:0] rgb565_t;
    typedef logic [1:0]       shade_t;

    localparam rgb565_t PAL_DEF_0 = 16'hE7DA;
    localparam rgb565_t PAL_DEF_1 = 16'h8E0E;
    localparam rgb565_t PAL_DEF_2 = 16'h334A;
    localparam rgb565_t PAL_DEF_3 = 16'h08C4;

    function automatic rgb565_t pal_default(input shade_t idx);
        case (idx)
            2'd0:    return PAL_DEF_0;
            2'd1:    return PAL_DEF_1;
            2'd2:    return PAL_DEF_2;
            default: return PAL_DEF_3;
        endcase
    endfunction

endpackage

// File: rtl/gb_fb_ram.sv
// Simple dual-port synchronous RAM holding the 2-bit shade frame store.
// Ports:
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, registered output, read-first on collision
module gb_fb_ram
    import gb_video_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports in one process: the read samples mem before the write lands.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/gb_frame_buffer.sv
// Captures the PPU shade stream into a single-buffered frame store and
// answers display coordinate requests with palette-mapped RGB565 colour.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   px_valid, px_shade, px_frame_start : PPU pixel stream
//   pix_en, req_x, req_y              : display request, advanced on pix_en
//   color                             : result for the request two ticks back
//   pal_we, pal_idx, pal_data         : palette write port
//   overflow                          : sticky, too many pixels in a frame
module gb_frame_buffer
    import gb_video_pkg::*;
#(
    parameter int             GB_W       = gb_video_pkg::GB_W,
    parameter int             GB_H       = gb_video_pkg::GB_H,
    parameter int             SCALE_LOG2 = 0,
    parameter int             H_OFF      = 160,
    parameter int             V_OFF      = 64,
    parameter logic [15:0]    BORDER     = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             px_valid,
    input  logic [1:0]       px_shade,
    input  logic             px_frame_start,
    input  logic             pix_en,
    input  logic [9:0]       req_x,
    input  logic [9:0]       req_y,
    output logic [RGB_W-1:0] color,
    input  logic             pal_we,
    input  logic [1:0]       pal_idx,
    input  logic [15:0]      pal_data,
    output logic             overflow
);

    localparam int AW   = FB_ADDR_W;
    localparam int FB_N = GB_W * GB_H;

    // Row base as (v<<7)+(v<<5); wraps modulo 2**AW like the address itself.
    function automatic logic [AW-1:0] row_base(input logic [10:0] v);
        logic [AW-1:0] v15;
        v15 = AW'(v);
        return (v15 << 7) + (v15 << 5);
    endfunction

    logic [AW-1:0] wr_addr;
    logic          wr_room;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;

    assign wr_room   = (wr_addr < AW'(FB_N));
    assign ram_we    = rst_n && px_valid && (px_frame_start || wr_room);
    assign ram_waddr = px_frame_start ? '0 : wr_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            overflow <= 1'b0;
        end else if (px_frame_start) begin
            overflow <= 1'b0;
            wr_addr  <= px_valid ? AW'(1) : '0;
        end else if (px_valid) begin
            if (wr_room) wr_addr <= wr_addr + 1'b1;
            else         overflow <= 1'b1;
        end
    end

    logic signed [10:0] dx, dy;
    logic        [10:0] sx, sy;
    logic               in_win_c;
    logic [AW-1:0]      rd_addr_c;

    assign dx = $signed({1'b0, req_x}) - $signed(11'(H_OFF));
    assign dy = $signed({1'b0, req_y}) - $signed(11'(V_OFF));
    // Only meaningful when dx/dy are non-negative; in_win masks the rest.
    assign sx = $unsigned(dx) >> SCALE_LOG2;
    assign sy = $unsigned(dy) >> SCALE_LOG2;
    assign in_win_c  = !dx[10] && !dy[10] && (sx < 11'(GB_W)) && (sy < 11'(GB_H));
    assign rd_addr_c = row_base(sy) + AW'(sx);

    // ---- stage p0: window test and frame-store address ----
    logic          vld_p0, in_win_p0;
    logic [AW-1:0] rd_addr_p0;

    always_ff @(posedge clk) begin
        if (!rst_n)      vld_p0 <= 1'b0;
        else if (pix_en) vld_p0 <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (pix_en) begin
            in_win_p0  <= in_win_c;
            rd_addr_p0 <= rd_addr_c;
        end
    end

    // ---- stage p1: frame-store read ----
    logic   vld_p1, in_win_p1;
    shade_t shade_p1;

    gb_fb_ram #(.DEPTH(FB_N), .ADDR_W(AW), .DATA_W(2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (px_shade),
        .re    (pix_en),
        .raddr (rd_addr_p0),
        .rdata (shade_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)      vld_p1 <= 1'b0;
        else if (pix_en) vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (pix_en) in_win_p1 <= in_win_p0;
    end

    // ---- stage p2: palette lookup and border select ----
    rgb565_t pal [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pal[i] <= pal_default(2'(i));
            color <= BORDER;
        end else begin
            if (pal_we) pal[pal_idx] <= pal_data;
            if (pix_en) color <= (vld_p1 && in_win_p1) ? pal[shade_p1] : BORDER;
        end
    end

endmodule
